decode_execute: RTL and testbench
=================================

DECODE_EXECUTE -- requirements
Module: decode_execute

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter CTRL_W, default 10, width of the packed decode control bundle.
REQ-003 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, rising-edge clock shared with the register file.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port rd1D, rd2D, input, DATA_W each, register file read data (r15 already substituted upstream).
REQ-008 Port ra1D, ra2D, wa3D, input, 4 each, decode source and destination register indices.
REQ-009 Port extImmD, input, DATA_W, extended immediate.
REQ-010 Port ctrlD, input, CTRL_W, packed controls {regWrite, memWrite, memtoReg, aluSrc, aluControl[1:0], flagWrite[1:0], branch, pcSrc}.
REQ-011 Port validD, input, 1, decode slot holds a real instruction.
REQ-012 Port aluResultM, wa3M, regWriteM, input, DATA_W/4/1, memory-stage forwarding source.
REQ-013 Port resultW, wa3W, regWriteW, input, DATA_W/4/1, writeback source (same signals drive the register file write port).
REQ-014 Port holdE, input, 1, downstream freeze request; flushE, input, 1, taken-branch kill.
REQ-015 Port srcAE, srcBE, writeDataE, output, DATA_W each, forwarded ALU operands and store data.
REQ-016 Port ctrlE, wa3E, validE, output, CTRL_W/4/1, registered execute-stage controls.
REQ-017 Port stallD, output, 1, combinational stall request to fetch/decode.
REQ-018 Port stallCount, output, CNT_W, saturating count of stallD cycles.

Function
REQ-019 D-side bypass: if regWriteW, wa3W==ra1D and ra1D!=15, the captured A operand SHALL be resultW instead of rd1D; same rule for ra2D/rd2D. This covers the same-edge write in the register file.
REQ-020 Register update priority, per rising edge:
  - holdE: all E registers keep their value.
  - else flushE: validE<=0, ctrlE<=0.
  - else stallD: validE<=0, ctrlE<=0.
  - else capture D inputs, validE<=validD.
REQ-021 Load-use hazard: stallD SHALL be 1 when validE & ctrlE.memtoReg & wa3E!=15 & (wa3E==ra1D | wa3E==ra2D), and 0 otherwise.
REQ-022 stallD SHALL be 1 while holdE=1; it SHALL NOT be raised by flushE alone.
REQ-023 Execute forwarding for A: select aluResultM if regWriteM & wa3M==ra1E & ra1E!=15; else resultW if regWriteW & wa3W==ra1E & ra1E!=15; else the registered operand. M has priority over W.
REQ-024 Execute forwarding for B applies the same rule using ra2E.
REQ-025 writeDataE SHALL be the forwarded B value; srcBE SHALL be extImmE when ctrlE.aluSrc=1, else the forwarded B value.
REQ-026 The forwarding paths SHALL be combinational, so forwarding adds zero cycles of latency; D-to-E latency is one cycle.
REQ-027 stallCount SHALL increment on each clock with stallD=1 and saturate at all ones.

Reset
REQ-028 While rst_n=0, all E registers SHALL read 0 (validE=0, ctrlE=0, srcAE/srcBE/writeDataE=0, wa3E=0) and stallCount SHALL be 0.
REQ-029 Reset asserted mid-stall SHALL drop stallD to 0 immediately, because validE=0.
REQ-030 The first edge after rst_n rises SHALL capture D normally.

Structure
REQ-031 A shared package SHALL hold:
  - DATA_W and CTRL_W;
  - the ctrl bit positions;
  - the forward-select encodings FWD_REG=00, FWD_WB=01, FWD_MEM=10;
  - the PC index constant 4'hF.
REQ-032 Forwarding selection and load-use detection SHALL live in one combinational sub-module named hazard_unit; all pipeline registers stay in decode_execute.

Verification
REQ-033 WB bypass: regWriteW=1, wa3W=3, resultW=0xA5A5_0001, ra1D=3, rd1D=0 -> next cycle srcAE=0xA5A5_0001.
REQ-034 M-over-W priority: wa3M=wa3W=ra1E=5, aluResultM=0x11, resultW=0x22 -> srcAE=0x11.
REQ-035 Load-use: LDR r2 in E, ADD using ra2D=2 in D -> stallD=1 for one cycle, one bubble (validE=0), stallCount=1, ADD enters E on the next edge.
REQ-036 Simultaneous events:
  - holdE=1 with flushE=1 -> E registers unchanged.
  - Next cycle holdE=0, flushE=1 -> validE=0, ctrlE=0.
REQ-037 r15 exclusion: regWriteM=1, wa3M=15, ra1E=15 -> no forwarding, srcAE equals the registered r15 value.
REQ-038 Async reset mid-stall: rst_n low between edges -> all outputs 0 and stallD=0 before the next clock edge.

Source files
------------

// File: rtl/decode_execute_pkg.sv
// decode_execute_pkg: shared widths, ctrl bit positions, forward-select codes and helpers
package decode_execute_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 10;

    localparam int CTRL_REGWRITE   = 9;
    localparam int CTRL_MEMWRITE   = 8;
    localparam int CTRL_MEMTOREG   = 7;
    localparam int CTRL_ALUSRC     = 6;
    localparam int CTRL_ALUCTRL_LO = 4;
    localparam int CTRL_FLAGWR_LO  = 2;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_PCSRC      = 0;

    localparam logic [3:0] PC_IDX = 4'hF;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // r15 is never a forwarding target: its value comes from the PC path upstream
    function automatic logic hit(input logic [3:0] ra, input logic [3:0] wa, input logic we);
        return we && wa == ra && ra != PC_IDX;
    endfunction

    function automatic fwd_e fwd_sel(input logic [3:0] ra, input logic [3:0] wa_m, input logic we_m,
                                     input logic [3:0] wa_w, input logic we_w);
        return hit(ra, wa_m, we_m) ? FWD_MEM : hit(ra, wa_w, we_w) ? FWD_WB : FWD_REG;
    endfunction

endpackage

// File: rtl/decode_execute_if.sv
// decode_execute_if: decode inputs, M/W forwarding sources and execute-stage outputs
interface decode_execute_if #(
    parameter int DATA_W = decode_execute_pkg::DATA_W,
    parameter int CTRL_W = decode_execute_pkg::CTRL_W,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] rd1D, rd2D, extImmD, aluResultM, resultW;
    logic [DATA_W-1:0] srcAE, srcBE, writeDataE;
    logic [3:0]        ra1D, ra2D, wa3D, wa3M, wa3W, wa3E;
    logic [CTRL_W-1:0] ctrlD, ctrlE;
    logic              validD, regWriteM, regWriteW, holdE, flushE;
    logic              validE, stallD;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output rd1D, rd2D, extImmD, aluResultM, resultW, ra1D, ra2D, wa3D, wa3M, wa3W,
               ctrlD, validD, regWriteM, regWriteW, holdE, flushE,
        input  srcAE, srcBE, writeDataE, wa3E, ctrlE, validE, stallD, stallCount
    );

    modport slave (
        input  rd1D, rd2D, extImmD, aluResultM, resultW, ra1D, ra2D, wa3D, wa3M, wa3W,
               ctrlD, validD, regWriteM, regWriteW, holdE, flushE,
        output srcAE, srcBE, writeDataE, wa3E, ctrlE, validE, stallD, stallCount
    );
endinterface

// File: rtl/decode_execute_hazard_unit.sv
// hazard_unit: combinational D-side bypass, E-side forward selection and load-use detection
module hazard_unit
    import decode_execute_pkg::*;
(
    input  logic [3:0] ra1_d,
    input  logic [3:0] ra2_d,
    input  logic [3:0] ra1_e,
    input  logic [3:0] ra2_e,
    input  logic [3:0] wa3_e,
    input  logic       valid_e,
    input  logic       mem_to_reg_e,
    input  logic [3:0] wa3_m,
    input  logic       reg_write_m,
    input  logic [3:0] wa3_w,
    input  logic       reg_write_w,
    output logic       byp_a,
    output logic       byp_b,
    output fwd_e       sel_a,
    output fwd_e       sel_b,
    output logic       load_use
);

    // D-side bypass covers the register file being written on the same edge we capture
    assign byp_a = hit(ra1_d, wa3_w, reg_write_w);
    assign byp_b = hit(ra2_d, wa3_w, reg_write_w);

    assign sel_a = fwd_sel(ra1_e, wa3_m, reg_write_m, wa3_w, reg_write_w);
    assign sel_b = fwd_sel(ra2_e, wa3_m, reg_write_m, wa3_w, reg_write_w);

    assign load_use = valid_e && mem_to_reg_e && wa3_e != PC_IDX && (wa3_e == ra1_d || wa3_e == ra2_d);

endmodule

// File: rtl/decode_execute.sv
// decode_execute: D->E pipeline registers with operand forwarding, load-use stall and stall counter
module decode_execute #(
    parameter int DATA_W = decode_execute_pkg::DATA_W,
    parameter int CTRL_W = decode_execute_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst_n,
    decode_execute_if.slave bus
);
    import decode_execute_pkg::*;

    logic [DATA_W-1:0] a_e, b_e, imm_e, a_d, b_d, fwd_a, fwd_b;
    logic [3:0]        ra1_e, ra2_e, wa3_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic              valid_e, load_use, byp_a, byp_b, stall;
    logic [CNT_W-1:0]  cnt;
    fwd_e              sel_a, sel_b;

    hazard_unit hu (
        .ra1_d       (bus.ra1D),
        .ra2_d       (bus.ra2D),
        .ra1_e       (ra1_e),
        .ra2_e       (ra2_e),
        .wa3_e       (wa3_e),
        .valid_e     (valid_e),
        .mem_to_reg_e(ctrl_e[CTRL_MEMTOREG]),
        .wa3_m       (bus.wa3M),
        .reg_write_m (bus.regWriteM),
        .wa3_w       (bus.wa3W),
        .reg_write_w (bus.regWriteW),
        .byp_a       (byp_a),
        .byp_b       (byp_b),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .load_use    (load_use)
    );

    // gating by rst_n keeps stallD low the moment reset is asserted, even with holdE high
    assign stall = rst_n && (bus.holdE || load_use);

    assign a_d = byp_a ? bus.resultW : bus.rd1D;
    assign b_d = byp_b ? bus.resultW : bus.rd2D;

    always_comb begin
        fwd_a = sel_a == FWD_MEM ? bus.aluResultM : sel_a == FWD_WB ? bus.resultW : a_e;
        fwd_b = sel_b == FWD_MEM ? bus.aluResultM : sel_b == FWD_WB ? bus.resultW : b_e;
    end

    // operands are forced to zero during reset so live M/W forwarding cannot leak through
    assign bus.srcAE      = rst_n ? fwd_a : '0;
    assign bus.writeDataE = rst_n ? fwd_b : '0;
    assign bus.srcBE      = !rst_n ? '0 : ctrl_e[CTRL_ALUSRC] ? imm_e : fwd_b;
    assign bus.ctrlE      = ctrl_e;
    assign bus.wa3E       = wa3_e;
    assign bus.validE     = valid_e;
    assign bus.stallD     = stall;
    assign bus.stallCount = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_e     <= '0;
            b_e     <= '0;
            imm_e   <= '0;
            ra1_e   <= '0;
            ra2_e   <= '0;
            wa3_e   <= '0;
            ctrl_e  <= '0;
            valid_e <= 1'b0;
        end else if (!bus.holdE) begin
            if (bus.flushE || stall) begin
                valid_e <= 1'b0;
                ctrl_e  <= '0;
            end else begin
                a_e     <= a_d;
                b_e     <= b_d;
                imm_e   <= bus.extImmD;
                ra1_e   <= bus.ra1D;
                ra2_e   <= bus.ra2D;
                wa3_e   <= bus.wa3D;
                ctrl_e  <= bus.ctrlD;
                valid_e <= bus.validD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (stall && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: tb/tb_decode_execute.sv
// tb_decode_execute: directed scenarios plus random stimulus against an instruction-level model
module tb_decode_execute;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_execute_if bus ();
    decode_execute_if #(.CNT_W(3)) sbus ();

    decode_execute dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    decode_execute #(.CNT_W(3)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

    localparam logic [9:0] C_LDR = 10'h280;
    localparam logic [9:0] C_ADD = 10'h200;

    int n_cmp = 0;
    int n_err = 0;

    // the instruction currently sitting in E, as the model sees it
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_a, m_b, m_imm;
    logic [3:0]  m_ra1, m_ra2, m_wa3;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_ra1 = 0; m_ra2 = 0; m_wa3 = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [3:0] ra, input logic [31:0] v);
        if (bus.regWriteM && bus.wa3M == ra && ra != 4'd15) return bus.aluResultM;
        if (bus.regWriteW && bus.wa3W == ra && ra != 4'd15) return bus.resultW;
        return v;
    endfunction

    function automatic logic [31:0] bypass(input logic [3:0] ra, input logic [31:0] v);
        return (bus.regWriteW && bus.wa3W == ra && ra != 4'd15) ? bus.resultW : v;
    endfunction

    function automatic logic exp_stall();
        return rst_n && (bus.holdE || (m_valid && m_ctrl[7] && m_wa3 != 4'd15 &&
                                       (m_wa3 == bus.ra1D || m_wa3 == bus.ra2D)));
    endfunction

    task automatic clear_in();
        bus.rd1D = 0; bus.rd2D = 0; bus.extImmD = 0; bus.aluResultM = 0; bus.resultW = 0;
        bus.ra1D = 0; bus.ra2D = 0; bus.wa3D = 0; bus.wa3M = 0; bus.wa3W = 0;
        bus.ctrlD = 0; bus.validD = 0; bus.regWriteM = 0; bus.regWriteW = 0;
        bus.holdE = 0; bus.flushE = 0;
    endtask

    task automatic check_all();
        logic [31:0] fb;
        #1;
        if (!rst_n) reset_model();
        fb = fwd(m_ra2, m_b);
        chk("srcAE", bus.srcAE, rst_n ? fwd(m_ra1, m_a) : 32'd0);
        chk("srcBE", bus.srcBE, rst_n ? (m_ctrl[6] ? m_imm : fb) : 32'd0);
        chk("writeDataE", bus.writeDataE, rst_n ? fb : 32'd0);
        chk("ctrlE", {22'd0, bus.ctrlE}, {22'd0, m_ctrl});
        chk("validE", {31'd0, bus.validE}, {31'd0, m_valid});
        chk("wa3E", {28'd0, bus.wa3E}, {28'd0, m_wa3});
        chk("stallD", {31'd0, bus.stallD}, {31'd0, exp_stall()});
        chk("stallCount", {16'd0, bus.stallCount}, m_cnt);
    endtask

    task automatic tick();
        logic st;
        st = exp_stall();
        @(posedge clk);
        if (!rst_n) reset_model();
        else begin
            if (st && m_cnt != 65535) m_cnt++;
            if (!bus.holdE) begin
                if (bus.flushE || st) begin
                    m_valid = 0; m_ctrl = 0;
                end else begin
                    m_a = bypass(bus.ra1D, bus.rd1D);
                    m_b = bypass(bus.ra2D, bus.rd2D);
                    m_imm = bus.extImmD;
                    m_ra1 = bus.ra1D; m_ra2 = bus.ra2D; m_wa3 = bus.wa3D;
                    m_ctrl = bus.ctrlD; m_valid = bus.validD;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
    endfunction

    initial begin
        reset_model();
        clear_in();
        sbus.rd1D = 0; sbus.rd2D = 0; sbus.extImmD = 0; sbus.aluResultM = 0; sbus.resultW = 0;
        sbus.ra1D = 0; sbus.ra2D = 0; sbus.wa3D = 0; sbus.wa3M = 0; sbus.wa3W = 0;
        sbus.ctrlD = 0; sbus.validD = 0; sbus.regWriteM = 0; sbus.regWriteW = 0;
        sbus.holdE = 1; sbus.flushE = 0;
        bus.regWriteM = 1; bus.aluResultM = 32'h5555_aaaa;
        repeat (2) begin check_all(); tick(); end
        rst_n = 1;
        // writeback bypass on the capture edge
        clear_in();
        bus.regWriteW = 1; bus.wa3W = 3; bus.resultW = 32'hA5A5_0001; bus.ra1D = 3; bus.validD = 1;
        check_all(); tick();
        clear_in();
        check_all(); chk("wb_bypass", bus.srcAE, 32'hA5A5_0001); tick();
        // M wins over W
        bus.ra1D = 5; bus.rd1D = 32'h99; bus.validD = 1;
        check_all(); tick();
        clear_in();
        bus.wa3M = 5; bus.wa3W = 5; bus.regWriteM = 1; bus.regWriteW = 1;
        bus.aluResultM = 32'h11; bus.resultW = 32'h22;
        check_all(); chk("m_over_w", bus.srcAE, 32'h11); tick();
        // r15 is never forwarded
        clear_in();
        bus.ra1D = 15; bus.rd1D = 32'h1234; bus.validD = 1;
        check_all(); tick();
        clear_in();
        bus.regWriteM = 1; bus.wa3M = 15; bus.aluResultM = 32'hdead;
        bus.regWriteW = 1; bus.wa3W = 15; bus.resultW = 32'hbeef;
        check_all(); chk("r15_no_fwd", bus.srcAE, 32'h1234); tick();
        // load-use: LDR r2 then ADD reading r2
        clear_in();
        bus.ctrlD = C_LDR; bus.wa3D = 2; bus.validD = 1;
        check_all(); tick();
        clear_in();
        bus.ra1D = 1; bus.ra2D = 2; bus.wa3D = 4; bus.ctrlD = C_ADD; bus.validD = 1;
        check_all(); chk("lu_stall", {31'd0, bus.stallD}, 1); tick();
        check_all();
        chk("lu_bubble", {31'd0, bus.validE}, 0);
        chk("lu_count", {16'd0, bus.stallCount}, 1);
        chk("lu_release", {31'd0, bus.stallD}, 0);
        tick();
        check_all();
        chk("lu_add_in_e", {28'd0, bus.wa3E}, 4);
        chk("lu_add_valid", {31'd0, bus.validE}, 1);
        // hold beats flush, then flush alone
        bus.wa3D = 9; bus.holdE = 1; bus.flushE = 1;
        check_all(); chk("hold_stall", {31'd0, bus.stallD}, 1); tick();
        check_all(); chk("hold_keep_wa3", {28'd0, bus.wa3E}, 4); chk("hold_keep_valid", {31'd0, bus.validE}, 1);
        bus.holdE = 0;
        check_all(); chk("flush_no_stall", {31'd0, bus.stallD}, 0); tick();
        check_all(); chk("flush_valid", {31'd0, bus.validE}, 0); chk("flush_ctrl", {22'd0, bus.ctrlE}, 0);
        // async reset in the middle of a stall
        clear_in();
        bus.ctrlD = C_LDR; bus.wa3D = 2; bus.validD = 1;
        check_all(); tick();
        clear_in();
        bus.ra2D = 2; bus.validD = 1; bus.regWriteM = 1; bus.aluResultM = 32'h77;
        check_all(); chk("rst_pre_stall", {31'd0, bus.stallD}, 1);
        rst_n = 0;
        check_all();
        chk("rst_stall", {31'd0, bus.stallD}, 0);
        chk("rst_valid", {31'd0, bus.validE}, 0);
        chk("rst_srcA", bus.srcAE, 0);
        chk("rst_count", {16'd0, bus.stallCount}, 0);
        tick();
        rst_n = 1;
        // first edge after reset captures
        clear_in();
        bus.wa3D = 7; bus.ctrlD = 10'h3ff; bus.validD = 1; bus.extImmD = 32'hcafe;
        check_all(); tick();
        check_all(); chk("first_capture", {28'd0, bus.wa3E}, 7); chk("first_srcB", bus.srcBE, 32'hcafe);
        tick();
        repeat (600) begin
            bus.rd1D = $urandom; bus.rd2D = $urandom; bus.extImmD = $urandom;
            bus.aluResultM = $urandom; bus.resultW = $urandom;
            bus.ra1D = rnd_reg(); bus.ra2D = rnd_reg(); bus.wa3D = rnd_reg();
            bus.wa3M = rnd_reg(); bus.wa3W = rnd_reg();
            bus.ctrlD = 10'($urandom_range(0, 1023)); bus.validD = 1'($urandom_range(0, 1));
            bus.regWriteM = 1'($urandom_range(0, 1)); bus.regWriteW = 1'($urandom_range(0, 1));
            bus.holdE = ($urandom_range(0, 9) == 0); bus.flushE = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            check_all(); tick();
        end
        rst_n = 1;
        clear_in();
        repeat (10) begin check_all(); tick(); end
        chk("sat_count", {29'd0, sbus.stallCount}, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
